// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_bit_adder.sv
// BitAdder: 1-bit full-adder cell.
// Ports: OPA, OPB, carryIn in; result (sum), carryOut out.
module BitAdder (
  input  logic OPA,
  input  logic OPB,
  input  logic carryIn,
  output logic result,
  output logic carryOut
);

  assign result   = OPA ^ OPB ^ carryIn;
  assign carryOut = (OPA & OPB)
                  | (carryIn & (OPA ^ OPB));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/sub controller: one BitAdder, LSB first, one bit per clock.
// Ports: clk, rst_n, start, sub, carry_in, opa, opb in;
// busy, done, result, carry_out, overflow, zero out.
// Build option: define SERIAL_ADDER_FLAGS_EN for overflow/zero flags.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_t        state_q;
  sa_state_t        state_d;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             carry_r;
  logic             bit_sum;
  logic             bit_cout;
  logic             load;
  logic             step;
  logic             last;

  BitAdder u_bit (
    .OPA      (shift_a[0]),
    .OPB      (shift_b[0]),
    .carryIn  (carry_r),
    .result   (bit_sum),
    .carryOut (bit_cout)
  );

  assign acc_next = {bit_sum, acc[WIDTH-1:1]};
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry_r <= 1'b0;
    end else begin
      unique case (1'b1)
        load: begin
          shift_a <= opa;
          shift_b <= sub ? ~opb : opb;
          carry_r <= sub | carry_in;
          cnt     <= '0;
          acc     <= '0;
        end
        step: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          carry_r <= bit_cout;
          acc     <= acc_next;
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else if (step && last) begin
      result    <= acc_next;
      carry_out <= bit_cout;
    end
  end

`ifdef SERIAL_ADDER_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  // On the final edge carry_r still holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (step && last) begin
      ovf_q  <= carry_r ^ bit_cout;
      zero_q <= (acc_next == '0);
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule
